// File: rtl/md_unit_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : md_unit_if
//  Description : Handshake/bus bundle between the E stage and the multiply/
//                divide unit.
//                master : drives md_op, flush, A, B; observes busy, md_stall,
//                         hi, lo
//                slave  : the md_unit side (inverse directions)
//                Signals: md_op[2:0] operation select, flush abort request,
//                         A/B forwarded rs/rt operands, busy operation in
//                         progress, md_stall hazard request, hi/lo registers.
//  Revision    : 1.0  initial release
// ============================================================================
interface md_unit_if #(
    parameter int WIDTH = 32
) ();
    logic [2:0]       md_op;
    logic             flush;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             md_stall;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output md_op, flush, A, B,
        input  busy, md_stall, hi, lo
    );

    modport slave (
        input  md_op, flush, A, B,
        output busy, md_stall, hi, lo
    );
endinterface
`default_nettype wire

// File: rtl/md_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : md_unit
//  Description : Multi-cycle multiply/divide unit holding the HI/LO registers
//                for the E stage. Executes mult/multu/div/divu (multi-cycle)
//                and mthi/mtlo (single edge); hi/lo feed mfhi/mflo.
//  Ports       : clk    rising-edge clock
//                reset  asynchronous active-high reset
//                bus    md_unit_if.slave:
//                         md_op  0 NONE,1 MULT,2 MULTU,3 DIV,4 DIVU,
//                                5 MTHI,6 MTLO,7 NONE
//                         flush  abort in-flight op / suppress new op
//                         A, B   operands
//                         busy   operation in progress (registered)
//                         md_stall busy or an md op being presented
//                         hi, lo HI/LO registers
//  Revision    : 1.0  initial release
// ============================================================================
module md_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  wire logic clk,
    input  wire logic reset,
    md_unit_if.slave  bus
);

    localparam logic [2:0] c_op_mult  = 3'd1;
    localparam logic [2:0] c_op_multu = 3'd2;
    localparam logic [2:0] c_op_div   = 3'd3;
    localparam logic [2:0] c_op_divu  = 3'd4;
    localparam logic [2:0] c_op_mthi  = 3'd5;
    localparam logic [2:0] c_op_mtlo  = 3'd6;

    localparam logic [WIDTH-1:0] c_one      = WIDTH'(1);
    localparam logic [WIDTH-1:0] c_all_ones = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] c_min_neg  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] c_cnt_mult = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] c_cnt_div  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] w_hi_nxt;
    logic [WIDTH-1:0] w_lo_nxt;
    logic [WIDTH-1:0] r_pend_hi;
    logic [WIDTH-1:0] r_pend_lo;
    logic             w_pend_ld;

    // ------------------------------------------------------------------
    // Result datapath. The whole result is formed in the accept cycle and
    // parked in the pending registers; the counter only models latency.
    // ------------------------------------------------------------------
    logic [2*WIDTH-1:0] w_prod_s;
    logic [2*WIDTH-1:0] w_prod_u;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH-1:0]   w_b_safe;
    logic [WIDTH-1:0]   w_b_mag_safe;
    logic [WIDTH-1:0]   w_uq;
    logic [WIDTH-1:0]   w_ur;
    logic [WIDTH-1:0]   w_sq_mag;
    logic [WIDTH-1:0]   w_sr_mag;
    logic [WIDTH-1:0]   w_sq;
    logic [WIDTH-1:0]   w_sr;
    logic               w_div_zero;
    logic               w_div_ovf;
    logic [WIDTH-1:0]   w_res_hi;
    logic [WIDTH-1:0]   w_res_lo;
    logic               w_md_start_op;

    assign w_prod_s = {{WIDTH{bus.A[WIDTH-1]}}, bus.A} * {{WIDTH{bus.B[WIDTH-1]}}, bus.B};
    assign w_prod_u = {{WIDTH{1'b0}}, bus.A} * {{WIDTH{1'b0}}, bus.B};

    // Signed division is done on magnitudes so truncation toward zero and
    // the remainder-takes-sign-of-A rule fall out of the sign fix-ups.
    assign w_a_neg      = bus.A[WIDTH-1];
    assign w_b_neg      = bus.B[WIDTH-1];
    assign w_a_mag      = w_a_neg ? (-bus.A) : bus.A;
    assign w_b_mag      = w_b_neg ? (-bus.B) : bus.B;
    assign w_div_zero   = (bus.B == '0);
    assign w_div_ovf    = (bus.A == c_min_neg) && (bus.B == c_all_ones);
    // Divisors are forced non-zero so the dividers never see /0; the
    // divide-by-zero result is substituted below.
    assign w_b_safe     = w_div_zero ? c_one : bus.B;
    assign w_b_mag_safe = w_div_zero ? c_one : w_b_mag;
    assign w_uq         = bus.A / w_b_safe;
    assign w_ur         = bus.A % w_b_safe;
    assign w_sq_mag     = w_a_mag / w_b_mag_safe;
    assign w_sr_mag     = w_a_mag % w_b_mag_safe;
    assign w_sq         = (w_a_neg ^ w_b_neg) ? (-w_sq_mag) : w_sq_mag;
    assign w_sr         = w_a_neg ? (-w_sr_mag) : w_sr_mag;

    always_comb begin
        w_res_hi = '0;
        w_res_lo = '0;
        case (bus.md_op)
            c_op_mult: begin
                w_res_hi = w_prod_s[2*WIDTH-1:WIDTH];
                w_res_lo = w_prod_s[WIDTH-1:0];
            end
            c_op_multu: begin
                w_res_hi = w_prod_u[2*WIDTH-1:WIDTH];
                w_res_lo = w_prod_u[WIDTH-1:0];
            end
            c_op_div: begin
                if (w_div_zero) begin
                    w_res_hi = bus.A;
                    w_res_lo = c_all_ones;
                end else if (w_div_ovf) begin
                    w_res_hi = '0;
                    w_res_lo = bus.A;
                end else begin
                    w_res_hi = w_sr;
                    w_res_lo = w_sq;
                end
            end
            c_op_divu: begin
                if (w_div_zero) begin
                    w_res_hi = bus.A;
                    w_res_lo = c_all_ones;
                end else begin
                    w_res_hi = w_ur;
                    w_res_lo = w_uq;
                end
            end
            default: begin
                w_res_hi = '0;
                w_res_lo = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Control FSM: next-state / next-register logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_hi_nxt    = r_hi;
        w_lo_nxt    = r_lo;
        w_pend_ld   = 1'b0;
        case (r_state)
            S_IDLE: begin
                // flush in IDLE suppresses every op, including MTHI/MTLO
                if (!bus.flush) begin
                    case (bus.md_op)
                        c_op_mult, c_op_multu: begin
                            w_state_nxt = S_RUN;
                            w_cnt_nxt   = c_cnt_mult;
                            w_pend_ld   = 1'b1;
                        end
                        c_op_div, c_op_divu: begin
                            w_state_nxt = S_RUN;
                            w_cnt_nxt   = c_cnt_div;
                            w_pend_ld   = 1'b1;
                        end
                        c_op_mthi: w_hi_nxt = bus.A;
                        c_op_mtlo: w_lo_nxt = bus.A;
                        default:   ;
                    endcase
                end
            end
            S_RUN: begin
                // flush has priority over the commit edge
                if (bus.flush) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_cnt_one) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                    w_hi_nxt    = r_pend_hi;
                    w_lo_nxt    = r_pend_lo;
                end else begin
                    w_cnt_nxt = r_cnt - c_cnt_one;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and data registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_pend_hi <= '0;
            r_pend_lo <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_hi    <= w_hi_nxt;
            r_lo    <= w_lo_nxt;
            if (w_pend_ld) begin
                r_pend_hi <= w_res_hi;
                r_pend_lo <= w_res_lo;
            end
        end
    end

    // md_stall covers the accept cycle too, so the hazard unit freezes the
    // next md instruction before busy has risen.
    assign w_md_start_op = (bus.md_op >= c_op_mult) && (bus.md_op <= c_op_divu);
    assign bus.busy      = (r_state == S_RUN);
    assign bus.md_stall  = bus.busy | w_md_start_op;
    assign bus.hi        = r_hi;
    assign bus.lo        = r_lo;

endmodule
`default_nettype wire
